// File: rtl/ocimem_debug_arbiter.sv
// JTAG debug-monitor memory sequencer and single-port debug RAM arbiter.
// Queues JTAG LOAD/WRITE/READ strobes in a 1-deep slot and shares the RAM with CPU
// debug-slave accesses using round-robin arbitration on contention.
// Optional build macro: OCIMEM_ROM_PROTECT_EN makes the low ROM_WORDS words read-only.
module ocimem_debug_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned ROM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_waitrequest,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {StIdle, StJRd, StCRd} state_e;
    typedef enum logic [1:0] {OpLoad, OpWrite, OpRead} op_e;

`ifdef OCIMEM_ROM_PROTECT_EN
    localparam logic RomProtect = 1'b1;
`else
    localparam logic RomProtect = 1'b0;
`endif

    state_e            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    op_e               pend_op_q, pend_op_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              rr_cpu_q, rr_cpu_d;   // 1: last grant went to the CPU

    logic jtag_strobe, jtag_mem_req, grant_jtag, grant_cpu;
    logic jtag_wr_blocked, cpu_wr_blocked, slot_leave, cpu_done;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    assign jtag_strobe     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jtag_mem_req    = pend_valid_q && (pend_op_q != OpLoad);
    // On contention the side that did not win last time gets the RAM.
    assign grant_jtag      = jtag_mem_req && (!cpu_req || rr_cpu_q);
    assign grant_cpu       = cpu_req && (!jtag_mem_req || !rr_cpu_q);
    assign jtag_wr_blocked = RomProtect && (32'(addr_q) < ROM_WORDS);
    assign cpu_wr_blocked  = RomProtect && (32'(cpu_addr) < ROM_WORDS);

    assign cpu_waitrequest = cpu_req & ~cpu_done;
    // Read data goes straight through on the completion cycle, then is held.
    assign cpu_rdata       = (state_q == StCRd) ? mem_rdata : cpu_rdata_q;
    assign MonDReg         = mon_dreg_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;

    // Next-state, RAM port and pending-slot control.
    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_op_d    = pend_op_q;
        pend_data_d  = pend_data_q;
        addr_d       = addr_q;
        mon_dreg_d   = mon_dreg_q;
        ready_d      = ready_q;
        error_d      = error_q;
        cpu_rdata_d  = cpu_rdata_q;
        rr_cpu_d     = rr_cpu_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = addr_q;
        mem_wdata    = pend_data_q;
        cpu_done     = 1'b0;
        slot_leave   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // LOAD needs no RAM, so it retires alongside any CPU grant.
                if (pend_valid_q && pend_op_q == OpLoad) begin
                    addr_d     = pend_data_q[ADDR_W-1:0];
                    error_d    = 1'b0;
                    ready_d    = 1'b1;
                    slot_leave = 1'b1;
                end
                if (grant_jtag) begin
                    rr_cpu_d = 1'b0;
                    if (pend_op_q == OpWrite) begin
                        if (jtag_wr_blocked) begin
                            error_d = 1'b1;
                        end else begin
                            mem_en = 1'b1;
                            mem_we = 1'b1;
                        end
                        addr_d     = addr_q + 1'b1;
                        ready_d    = 1'b1;
                        slot_leave = 1'b1;
                    end else begin
                        mem_en  = 1'b1;
                        state_d = StJRd;
                    end
                end else if (grant_cpu) begin
                    rr_cpu_d  = 1'b1;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    if (cpu_we) begin
                        mem_en   = !cpu_wr_blocked;
                        mem_we   = !cpu_wr_blocked;
                        cpu_done = 1'b1;
                    end else begin
                        mem_en  = 1'b1;
                        state_d = StCRd;
                    end
                end
            end
            StJRd: begin
                mon_dreg_d = mem_rdata;
                addr_d     = addr_q + 1'b1;
                ready_d    = 1'b1;
                slot_leave = 1'b1;
                state_d    = StIdle;
            end
            StCRd: begin
                cpu_rdata_d = mem_rdata;
                cpu_done    = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (slot_leave) begin
            pend_valid_d = 1'b0;
        end
        // A strobe may refill the slot on the cycle it empties; otherwise a full slot drops it.
        if (jtag_strobe) begin
            if (!pend_valid_q || slot_leave) begin
                pend_valid_d = 1'b1;
                ready_d      = 1'b0;
                if (take_action_ocimem_a) begin
                    pend_op_d   = OpLoad;
                    pend_data_d = 32'(jdo[17 +: ADDR_W]);
                end else if (take_action_ocimem_b) begin
                    pend_op_d   = OpWrite;
                    pend_data_d = jdo[34:3];
                end else begin
                    pend_op_d   = OpRead;
                end
            end else begin
                error_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_op_q    <= OpLoad;
            pend_data_q  <= '0;
            addr_q       <= '0;
            mon_dreg_q   <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            cpu_rdata_q  <= '0;
            rr_cpu_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_data_q  <= pend_data_d;
            addr_q       <= addr_d;
            mon_dreg_q   <= mon_dreg_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            cpu_rdata_q  <= cpu_rdata_d;
            rr_cpu_q     <= rr_cpu_d;
        end
    end

endmodule

// File: doc/ocimem_debug_arbiter.md
Name: ocimem_debug_arbiter

Overview:
- Sequences JTAG debug-monitor memory operations decoded from the debug module's sysclk-side action strobes (take_action_ocimem_a/b, take_no_action_ocimem_a with jdo).
- Shares one single-port on-chip debug RAM between the JTAG debugger and the CPU's debug-slave accesses.
- Returns read data and status to the debug scan chain via MonDReg, monitor_ready and monitor_error.

Parameters:
- ADDR_W, 8, debug RAM word-address width; RAM depth is 2^ADDR_W words of 32 bits.
- ROM_WORDS, 64, number of low words treated as read-only when OCIMEM_ROM_PROTECT_EN is defined.

Ports:
- clk  in  1  single system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  debug data captured from JTAG.
- take_action_ocimem_a  in  1  one-cycle strobe: load address, addr <= jdo[17+ADDR_W-1:17].
- take_action_ocimem_b  in  1  one-cycle strobe: write jdo[34:3] at addr, then addr++.
- take_no_action_ocimem_a  in  1  one-cycle strobe: read at addr into MonDReg, then addr++.
- cpu_req  in  1  CPU debug-slave request; held until accepted.
- cpu_we  in  1  CPU write when 1, read when 0.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  CPU read data; valid on the cycle cpu_waitrequest falls for a read.
- cpu_waitrequest  out  1  equals cpu_req & ~cpu_done.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, registered, 1-cycle latency.
- MonDReg  out  32  JTAG read-back register.
- monitor_ready  out  1  last JTAG operation complete.
- monitor_error  out  1  sticky error.

Behaviour:
- Reset (async, any state, mid-operation included):
  - FSM goes to IDLE; the pending slot is emptied.
  - addr=0, MonDReg=0, monitor_ready=0, monitor_error=0, cpu_rdata=0, rr_last=CPU.
  - mem_en, mem_we and cpu_done are 0.
- JTAG strobes are mutually exclusive and go into a 1-deep pending slot {op: LOAD/WRITE/READ, addr or data}.
  - Acceptance clears monitor_ready.
  - A strobe that arrives while the slot is full and not leaving that cycle is dropped and sets monitor_error. This is the overrun rule.
  - A strobe arriving on the cycle the slot is consumed is accepted, with no error.
- LOAD does not use the RAM.
  - In IDLE it completes in 1 cycle: addr updated, monitor_error cleared, monitor_ready=1.
- Arbitration happens in IDLE, once per access, between a pending WRITE/READ and cpu_req.
  - With a single requester, that requester wins.
  - On contention, round-robin: the winner is the side opposite rr_last.
  - rr_last updates to the winner on every grant.
- FSM states: IDLE, J_RD, C_RD.
  - IDLE, JTAG WRITE granted:
    - mem_en=1, mem_we=1, mem_addr=addr, mem_wdata=pending data.
    - addr++, slot freed, monitor_ready=1 next cycle.
    - Stay in IDLE. Latency is 1 cycle.
  - IDLE, JTAG READ granted: mem_en=1, mem_we=0, go to J_RD.
  - J_RD: MonDReg<=mem_rdata, addr++, slot freed, monitor_ready=1, go to IDLE. Latency is 2 cycles.
  - IDLE, CPU write granted: RAM write issued, cpu_done=1 in the same cycle.
  - IDLE, CPU read granted: RAM read issued, go to C_RD.
  - C_RD: cpu_rdata=mem_rdata, cpu_done=1, go to IDLE.
- addr increments modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- monitor_error clears only on an accepted LOAD, or on reset.

Optional Feature:
- Macro: OCIMEM_ROM_PROTECT_EN.
- When defined:
  - Any write with address < ROM_WORDS keeps mem_we=0 and mem_en=0.
  - A JTAG write still increments addr, sets monitor_ready, and sets monitor_error.
  - A CPU write completes normally (cpu_done=1) with the data discarded.
  - Reads are unaffected.
- When undefined: all addresses are writable and ROM_WORDS is ignored.

Test Plan:
- JTAG LOAD addr=0x10, then WRITE 0xDEADBEEF, then LOAD 0x10, then READ -> mem write at 0x10; MonDReg=0xDEADBEEF two cycles after the READ strobe; addr=0x11; monitor_ready=1.
- LOAD 0xFF (ADDR_W=8), then two READs -> reads at 0xFF then 0x00 (wrap).
- cpu_req read at 0x20 held continuously while JTAG READs arrive every 4 cycles -> grants alternate JTAG/CPU; cpu_waitrequest drops every other access; no starvation.
- Two JTAG WRITE strobes on consecutive cycles while a CPU read is in C_RD -> second strobe dropped; monitor_error=1; a following LOAD clears it.
- reset_n asserted in J_RD -> all outputs at reset values immediately; no MonDReg update; pending slot empty after release.
- With OCIMEM_ROM_PROTECT_EN and ROM_WORDS=64: JTAG write at 0x05 -> mem_we stays 0, monitor_error=1; CPU write at 0x05 -> cpu_waitrequest drops, RAM unchanged; write at 0x40 -> mem_we=1.
